// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared divisor type and reset-default divisor helper for the baud generator
package uart_baud_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_t;
  function automatic div_t calc_default_div(longint clk_freq, longint baud, longint oversample, int frac_w);
    longint den;
    div_t d;
    den = oversample * baud;
    d.int_part = 32'(clk_freq / den);
    d.frac_part = 32'(((clk_freq << frac_w) / den) % (longint'(1) << frac_w));
    return d;
  endfunction
endpackage

// File: rtl/uart_frac_divider.sv
// uart_frac_divider: registered tick every div_int clocks, stretched by one when the fraction overflows
module uart_frac_divider #(
  parameter int INT_W = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              en,
  input  logic              clear,
  input  logic              load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              term,
  output logic              tick
);
  localparam logic [INT_W:0] ONE = 1;
  logic [INT_W:0] cnt, period;
  logic [FRAC_W-1:0] acc;
  logic carry;
  logic [FRAC_W:0] sum;
  always_comb begin
    period = {1'b0, div_int} + {{INT_W{1'b0}}, carry};
    sum = {1'b0, acc} + {1'b0, div_frac};
    term = en & ~clear & (cnt == period - ONE);
  end
  // load realigns the fractional phase to a fresh divisor at a bit boundary
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      cnt <= '0;
      acc <= '0;
      carry <= 1'b0;
      tick <= 1'b0;
    end else if (!en || clear) begin
      cnt <= '0;
      acc <= '0;
      carry <= 1'b0;
      tick <= 1'b0;
    end else if (term) begin
      cnt <= '0;
      tick <= 1'b1;
      {carry, acc} <= load ? '0 : sum;
    end else begin
      cnt <= cnt + ONE;
      tick <= 1'b0;
    end
endmodule

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: programmable fractional UART baud tick generator with bit-aligned divisor update
module uart_baud_gen_frac
  import uart_baud_pkg::*;
#(
  parameter int CLK_FREQ = 48000000,
  parameter int DEFAULT_BAUD = 1000000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int INT_W = 16,
  parameter int FRAC_W = 4
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic                          en,
  input  logic                          restart,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [INT_W-1:0]              cfg_int,
  input  logic [FRAC_W-1:0]             cfg_frac,
  output logic                          cfg_err,
  output logic                          rx_tick,
  output logic                          rx_mid,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_cnt
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam div_t DEF = calc_default_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
  localparam logic [INT_W-1:0] DEF_INT = DEF.int_part[INT_W-1:0];
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF.frac_part[FRAC_W-1:0];
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  if (DEF_INT == '0) begin : g_bad_default
    $error("default divisor must be at least 1");
  end
  if (OVERSAMPLE < 4 || (1 << OS_W) != OVERSAMPLE) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two, at least 4");
  end
  logic [INT_W-1:0] act_int, pend_int;
  logic [FRAC_W-1:0] act_frac, pend_frac;
  logic pend_vld, term, apply, accept, reject;
  logic [OS_W-1:0] os_next;
  assign cfg_ready = ~pend_vld;
  // os_next is the phase shown during the tick being issued now
  always_comb begin
    os_next = os_cnt + OS_W'(rx_tick);
    apply = pend_vld & (en ? term & (os_next == OS_LAST) : 1'b1);
    accept = cfg_valid & ~pend_vld & (cfg_int != '0);
    reject = cfg_valid & ~pend_vld & (cfg_int == '0);
  end
  uart_frac_divider #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_div (
    .clk(clk),
    .areset_n(areset_n),
    .en(en),
    .clear(restart),
    .load(apply),
    .div_int(act_int),
    .div_frac(act_frac),
    .term(term),
    .tick(rx_tick)
  );
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      act_int <= DEF_INT;
      act_frac <= DEF_FRAC;
      pend_int <= '0;
      pend_frac <= '0;
      pend_vld <= 1'b0;
      os_cnt <= '0;
      rx_mid <= 1'b0;
      tx_tick <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      os_cnt <= (!en || restart) ? '0 : os_next;
      rx_mid <= term & (os_next == OS_MID);
      tx_tick <= term & (os_next == OS_LAST);
      cfg_err <= reject;
      pend_vld <= accept | (pend_vld & ~apply);
      if (accept) begin
        pend_int <= cfg_int;
        pend_frac <= cfg_frac;
      end
      if (apply) begin
        act_int <= pend_int;
        act_frac <= pend_frac;
      end
    end
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: table, directed and random checks against a countdown reference model
module tb_uart_baud_gen_frac;
  localparam longint CLK_FREQ = 48000000;
  localparam longint BAUD = 1000000;
  localparam int OS = 16;
  localparam int FRAC_MOD = 16;
  localparam int DEF_INT = int'(CLK_FREQ / (OS * BAUD));
  localparam int DEF_FRAC = int'(((CLK_FREQ * FRAC_MOD) / (OS * BAUD)) % FRAC_MOD);
  logic clk = 0, areset_n = 1, en = 0, restart = 0, cfg_valid = 0;
  logic [15:0] cfg_int = '0;
  logic [3:0] cfg_frac = '0;
  logic cfg_ready, cfg_err, rx_tick, rx_mid, tx_tick;
  logic [3:0] os_cnt;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit started = 0;
  uart_baud_gen_frac dut (
    .clk(clk), .areset_n(areset_n), .en(en), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_int(cfg_int), .cfg_frac(cfg_frac),
    .cfg_err(cfg_err), .rx_tick(rx_tick), .rx_mid(rx_mid), .tx_tick(tx_tick), .os_cnt(os_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
    end
  endtask
  // reference: clocks left until the next tick, phase accumulated as an integer fraction
  int unsigned m_int, m_frac, m_pint, m_pfrac, m_left, m_acc, m_ticks;
  bit m_pend, e_tick, e_mid, e_tx, e_err;
  int unsigned e_os;
  task automatic m_reset();
    m_int = DEF_INT; m_frac = DEF_FRAC; m_pend = 0; m_left = DEF_INT; m_acc = 0; m_ticks = 0;
    e_tick = 0; e_mid = 0; e_tx = 0; e_err = 0; e_os = 0;
  endtask
  task automatic m_step();
    bit old_pend = m_pend;
    e_err = cfg_valid && !old_pend && cfg_int == 0;
    e_tick = 0; e_mid = 0; e_tx = 0;
    if (!en || restart) begin
      if (!en && old_pend) begin m_int = m_pint; m_frac = m_pfrac; m_pend = 0; end
      m_acc = 0; m_ticks = 0; m_left = m_int; e_os = 0;
    end else begin
      m_left--;
      e_os = m_ticks % OS;
      if (m_left == 0) begin
        e_tick = 1; e_mid = e_os == OS / 2 - 1; e_tx = e_os == OS - 1; m_ticks++;
        m_acc += m_frac;
        m_left = m_int + (m_acc >= FRAC_MOD ? 1 : 0);
        m_acc = m_acc % FRAC_MOD;
        if (e_tx && old_pend) begin
          m_int = m_pint; m_frac = m_pfrac; m_pend = 0; m_acc = 0; m_left = m_int;
        end
      end
    end
    if (cfg_valid && !old_pend && cfg_int != 0) begin m_pend = 1; m_pint = cfg_int; m_pfrac = cfg_frac; end
  endtask
  always @(posedge clk or negedge areset_n)
    if (!areset_n) m_reset();
    else m_step();
  always @(negedge clk)
    if (started) begin
      check("rx_tick", rx_tick, e_tick);
      check("rx_mid", rx_mid, e_mid);
      check("tx_tick", tx_tick, e_tx);
      check("cfg_err", cfg_err, e_err);
      check("cfg_ready", cfg_ready, !m_pend);
      check("os_cnt", os_cnt, e_os);
    end
  task automatic wait_tx(output int t);
    int n = 0;
    do begin @(negedge clk); n++; end while (!tx_tick && n < 3000);
    if (!tx_tick) check("tx_timeout", 0, 1);
    t = cyc;
  endtask
  task automatic wait_rx(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rx_tick && n < 300);
    if (!rx_tick) check("rx_timeout", 0, 1);
  endtask
  task automatic offer(input int ci, input int cf);
    cfg_valid = 1; cfg_int = 16'(ci); cfg_frac = 4'(cf);
    @(negedge clk);
    cfg_valid = 0;
  endtask
  typedef struct {
    int unsigned ci;
    int unsigned cf;
    bit err;
    int unsigned bit_clks;
  } vec_t;
  vec_t tbl[8];
  initial begin
    int first_rx, first_mid, first_tx, os_at_mid, n, t0, t1, t2, t3, ta, tb, tc, t_rel;
    tbl = '{'{3, 8, 0, 56}, '{5, 0, 0, 80}, '{0, 7, 1, 80}, '{1, 0, 0, 16},
            '{2, 4, 0, 36}, '{4, 15, 0, 79}, '{0, 0, 1, 79}, '{3, 0, 0, 48}};
    #1 areset_n = 0;
    started = 1;
    repeat (3) @(negedge clk);
    areset_n = 1;
    @(negedge clk);
    // defaults: tick every 3 clk, mid at os 7 on clk 24, bit of 48 clk
    en = 1; first_rx = 0; first_mid = 0; first_tx = 0; os_at_mid = -1; t0 = 0;
    for (int i = 1; i <= 200 && first_tx == 0; i++) begin
      @(negedge clk);
      if (rx_tick && first_rx == 0) first_rx = i;
      if (rx_mid && first_mid == 0) begin first_mid = i; os_at_mid = os_cnt; end
      if (tx_tick && first_tx == 0) begin first_tx = i; t0 = cyc; end
    end
    check("t1_first_rx", first_rx, 3);
    check("t1_first_mid", first_mid, 24);
    check("t1_mid_os", os_at_mid, 7);
    check("t1_first_tx", first_tx, 48);
    // mid-bit config waits for the bit boundary
    repeat (10) @(negedge clk);
    offer(5, 0);
    check("t3_ready_pending", cfg_ready, 0);
    wait_tx(t1);
    check("t3_old_bit", t1 - t0, 48);
    check("t3_ready_after", cfg_ready, 1);
    wait_rx(n);
    check("t3_new_period", n, 5);
    wait_tx(t2);
    check("t3_new_bit", t2 - t1, 80);
    // rejected divisor
    offer(0, 3);
    check("t5_err", cfg_err, 1);
    check("t5_ready", cfg_ready, 1);
    @(negedge clk);
    check("t5_err_cleared", cfg_err, 0);
    wait_tx(t3);
    check("t5_bit_unchanged", t3 - t2, 80);
    // restart coincident with a terminal count
    n = 0;
    while (m_left != 1 && n < 100) begin @(negedge clk); n++; end
    check("t4_found_terminal", m_left, 1);
    restart = 1;
    @(negedge clk);
    restart = 0;
    check("t4_no_tick", rx_tick, 0);
    check("t4_os_zero", os_cnt, 0);
    wait_rx(n);
    check("t4_next_tick", n, 5);
    // async reset mid-bit with a pending config
    wait_tx(t0);
    offer(7, 0);
    check("t6_pending", cfg_ready, 0);
    repeat (10) @(negedge clk);
    #2 areset_n = 0;
    #1;
    check("t6_rx_tick", rx_tick, 0);
    check("t6_rx_mid", rx_mid, 0);
    check("t6_tx_tick", tx_tick, 0);
    check("t6_cfg_err", cfg_err, 0);
    check("t6_os_cnt", os_cnt, 0);
    check("t6_cfg_ready", cfg_ready, 1);
    repeat (2) @(negedge clk);
    areset_n = 1;
    t_rel = cyc;
    wait_rx(n);
    check("t6_default_period", n, 3);
    wait_tx(t1);
    check("t6_default_bit", t1 - t_rel, 48);
    // divisor table applied while stopped
    foreach (tbl[i]) begin
      en = 0;
      repeat (2) @(negedge clk);
      offer(tbl[i].ci, tbl[i].cf);
      check("tbl_err", cfg_err, tbl[i].err);
      check("tbl_ready", cfg_ready, tbl[i].err);
      @(negedge clk);
      en = 1;
      wait_tx(ta);
      wait_tx(tb);
      wait_tx(tc);
      check("tbl_bit_clks", tc - tb, tbl[i].bit_clks);
    end
    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom % 64) != 0;
      restart = ($urandom % 100) == 0;
      cfg_valid = ($urandom % 40) == 0;
      cfg_int = 16'($urandom % 6);
      cfg_frac = 4'($urandom % 16);
      @(negedge clk);
    end
    en = 0; restart = 0; cfg_valid = 0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
